// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronises and debounces the two coin sensors,
// emits a single-cycle coin code per valid coin, rejects ambiguous or
// disabled coins, flags a jammed chute and counts accepted coins.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_5,
    input  logic       sense_10,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic [7:0] accepted_cnt
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(JAM_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StEmit,
        StRelease,
        StJam
    } state_e;

    logic [1:0]    s5_sync_q, s10_sync_q;
    logic          s5, s10;
    state_e        state_q, state_d;
    logic          sel_q, sel_d;      // latched sensor: 1 = 10-unit
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    coin_q, coin_d;
    logic          reject_q, reject_d;
    logic          jam_q, jam_d;
    logic [7:0]    acc_q, acc_d;
    logic          lat, oth;

    assign s5  = s5_sync_q[1];
    assign s10 = s10_sync_q[1];

    // Latched sensor and the competing one, as seen by the debouncer.
    assign lat = sel_q ? s10 : s5;
    assign oth = sel_q ? s5 : s10;

    // Two-flop synchronisers for the asynchronous raw sensors.
    always_ff @(posedge clk) begin
        if (rst) begin
            s5_sync_q  <= 2'b00;
            s10_sync_q <= 2'b00;
        end else begin
            s5_sync_q  <= {s5_sync_q[0], sense_5};
            s10_sync_q <= {s10_sync_q[0], sense_10};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sel_q    <= 1'b0;
            dcnt_q   <= '0;
            hold_q   <= '0;
            coin_q   <= 2'b00;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            acc_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            dcnt_q   <= dcnt_d;
            hold_q   <= hold_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
            acc_q    <= acc_d;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        dcnt_d   = dcnt_q;
        hold_d   = hold_q;
        coin_d   = 2'b00;
        reject_d = 1'b0;
        jam_d    = 1'b0;
        acc_d    = acc_q;
        case (state_q)
            StIdle: begin
                if (s5 && s10) begin
                    reject_d = 1'b1;
                    hold_d   = '0;
                    state_d  = StRelease;
                end else if (s5 ^ s10) begin
                    if (enable) begin
                        sel_d   = s10;
                        dcnt_d  = DW'(1);
                        state_d = StDebounce;
                    end else begin
                        reject_d = 1'b1;
                        hold_d   = '0;
                        state_d  = StRelease;
                    end
                end
            end
            StDebounce: begin
                if (oth) begin
                    reject_d = 1'b1;
                    hold_d   = '0;
                    state_d  = StRelease;
                end else if (!lat) begin
                    // Too short: treat as a glitch, nothing reported.
                    state_d = StIdle;
                end else if (dcnt_q == DW'(DEBOUNCE_CYCLES)) begin
                    coin_d  = sel_q ? 2'b10 : 2'b01;
                    state_d = StEmit;
                    if (acc_q != 8'hFF) begin
                        acc_d = acc_q + 8'd1;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            StEmit: begin
                hold_d  = '0;
                state_d = StRelease;
            end
            StRelease: begin
                if (!s5 && !s10) begin
                    hold_d  = '0;
                    state_d = StIdle;
                end else if (hold_q == HW'(JAM_CYCLES - 1)) begin
                    hold_d  = hold_q + HW'(1);
                    jam_d   = 1'b1;
                    state_d = StJam;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StJam: begin
                if (!s5 && !s10) begin
                    hold_d  = '0;
                    state_d = StIdle;
                end else begin
                    jam_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign coin         = coin_q;
    assign reject       = reject_q;
    assign jam          = jam_q;
    assign accepted_cnt = acc_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues expected coin/reject
// events with the edge they must appear after; a monitor pops and compares.
module tb_coin_acceptor;

    localparam int KC5  = 0;
    localparam int KC10 = 1;
    localparam int KREJ = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense_5;
    logic       sense_10;
    logic       enable;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [7:0] accepted_cnt;

    typedef struct {
        int          kind;
        int unsigned at;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned edge_n = 0;
    int          checks = 0;
    int          passes = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .JAM_CYCLES     (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sense_5     (sense_5),
        .sense_10    (sense_10),
        .enable      (enable),
        .coin        (coin),
        .reject      (reject),
        .jam         (jam),
        .accepted_cnt(accepted_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_n);
    endtask

    task automatic expect_ev(input int kind, input int unsigned at);
        exp_t x;
        x.kind = kind;
        x.at   = at;
        sb_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin_pulse(input bit ten, input int len);
        if (ten) sense_10 = 1'b1;
        else sense_5 = 1'b1;
        step(len);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
    endtask

    // Monitor: every coin or reject pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        if (coin != 2'b00 || reject) begin
            k = reject ? KREJ : (coin == 2'b01) ? KC5 : (coin == 2'b10) ? KC10 : 3;
            if (coin != 2'b00 && reject) check("coin_with_reject", 1, 0);
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got kind %0d at edge %0d, required none",
                         k, edge_n);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", k, e.kind);
                check("event_edge", edge_n, e.at);
            end
        end
    end

    initial begin
        int exp_cnt;
        int unsigned e;

        // Reset held with both sensors high.
        rst      = 1'b1;
        sense_5  = 1'b1;
        sense_10 = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_coin", coin, 0);
            check("reset_reject", reject, 0);
            check("reset_jam", jam, 0);
            check("reset_cnt", accepted_cnt, 0);
        end
        expect_ev(KREJ, edge_n + 3);
        rst = 1'b0;
        step(6);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        step(5);

        // Reset mid-coin abandons it silently.
        sense_5 = 1'b1;
        step(4);
        rst     = 1'b1;
        sense_5 = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        check("midreset_cnt", accepted_cnt, 0);

        // Clean 5-unit coin, 10 cycles.
        expect_ev(KC5, edge_n + 7);
        coin_pulse(1'b0, 10);
        check("clean5_cnt", accepted_cnt, 1);
        step(4);

        // Glitches on the 10-unit sensor: 4 cycles, gap 2, 3 cycles.
        coin_pulse(1'b1, 4);
        step(2);
        coin_pulse(1'b1, 3);
        step(4);
        check("glitch_cnt", accepted_cnt, 1);

        // Ambiguous coin: 10-unit sensor rises while 5-unit debounces.
        e = edge_n;
        expect_ev(KREJ, e + 5);
        sense_5 = 1'b1;
        step(2);
        sense_10 = 1'b1;
        step(6);
        sense_5  = 1'b0;
        sense_10 = 1'b0;
        step(4);
        check("ambig_cnt", accepted_cnt, 1);

        // Clean 10-unit coin afterwards.
        expect_ev(KC10, edge_n + 7);
        coin_pulse(1'b1, 6);
        step(4);
        check("clean10_cnt", accepted_cnt, 2);

        // Disabled coin held long enough to jam.
        enable   = 1'b0;
        e        = edge_n;
        expect_ev(KREJ, e + 3);
        sense_10 = 1'b1;
        step(1002);
        check("jam_before_limit", jam, 0);
        step(1);
        check("jam_at_limit", jam, 1);
        step(97);
        sense_10 = 1'b0;
        step(2);
        check("jam_held", jam, 1);
        step(1);
        check("jam_cleared", jam, 0);
        check("jam_cnt", accepted_cnt, 2);
        enable = 1'b1;
        step(4);

        // 256 minimum-length 10-unit coins; counter saturates at 255.
        exp_cnt = 2;
        for (int i = 0; i < 256; i++) begin
            expect_ev(KC10, edge_n + 7);
            coin_pulse(1'b1, 5);
            step(4);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check("sat_cnt", accepted_cnt, exp_cnt);
        end

        step(10);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that turns the two raw coin-chute sensors into the 2-bit coin code consumed by the vending controller's `in` port. It synchronises and debounces each sensor and rejects coins that are ambiguous, too short, or offered while acceptance is disabled. It flags a jammed chute and keeps a saturating count of accepted coins. Every valid coin produces exactly one single-cycle code on `coin`; all other cycles carry 00.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised-high samples required to accept a coin (≥1).
- `JAM_CYCLES`, default 1000: maximum sensor-high cycles after acceptance or rejection before `jam` asserts.
- `clk` in, 1: single clock; all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `sense_5` in, 1: raw 5-unit sensor; asynchronous and bouncy.
- `sense_10` in, 1: raw 10-unit sensor; asynchronous and bouncy.
- `enable` in, 1: accept coins when 1; coins offered while 0 are rejected.
- `coin` out, 2: 01 = 5-unit, 10 = 10-unit, 00 = none; 11 is never driven.
- `reject` out, 1: one-cycle pulse per rejected coin.
- `jam` out, 1: level; chute blocked.
- `accepted_cnt` out, 8: accepted-coin count, saturates at 255.

## Operation
- Synchronisation: each sensor passes through a 2-FF synchroniser, reset to 0. The FSM sees only the synchronised `s5` and `s10`.
- Reset: all outputs are 0, the FSM is in IDLE, and all counters and synchroniser flops are 0. A reset mid-coin abandons it: no `coin`, no `reject`.
- FSM states: IDLE, DEBOUNCE, EMIT, RELEASE, JAM.
- IDLE:
  - Exactly one sensor high and `enable`=1: latch which sensor, set cnt=1, go to DEBOUNCE.
  - Both sensors high: pulse `reject`, go to RELEASE.
  - Exactly one sensor high and `enable`=0: pulse `reject`, go to RELEASE.
- DEBOUNCE:
  - Latched sensor high, other low, cnt<D: cnt++.
  - Latched sensor high, other low, cnt==D: go to EMIT and drive the coin code.
  - Latched sensor drops: go to IDLE silently (glitch, no `reject`).
  - Other sensor rises: pulse `reject`, go to RELEASE.
  - `enable` is sampled only in IDLE; dropping it during DEBOUNCE does not abort.
- EMIT: lasts one cycle. `coin` carries the code; `accepted_cnt` increments unless already 255. Go to RELEASE.
- RELEASE:
  - Hold cnt counts cycles with either sensor high.
  - Both sensors low: go to IDLE, clear hold cnt.
  - Hold cnt reaches `JAM_CYCLES`: go to JAM.
- JAM: `jam`=1 and all coins are ignored. Both sensors low for one sample: clear `jam`, go to IDLE.
- Widths: debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits; hold counter is `$clog2(JAM_CYCLES+1)` bits. Neither counter wraps.
- `coin`, `reject`, and `jam` are registered outputs.

## Timing
- If a raw sensor is first sampled high at edge k, `s` is visible to the FSM at edge k+2.
- The FSM enters DEBOUNCE at edge k+2. `coin` is asserted after edge k+2+D and deasserted after edge k+3+D. With D=4 that is k+6 and k+7.
- Minimum accepted raw pulse: D+1 consecutive samples. A shorter pulse produces no output.
- `reject` asserts the cycle after the offending sample is seen in IDLE or DEBOUNCE, and lasts exactly one cycle.
- `jam` asserts after edge (entry to RELEASE)+`JAM_CYCLES` if a sensor is still high. It clears one cycle after both sensors are seen low.
- `coin` and `reject` never assert in the same cycle. At most one `coin` pulse per IDLE→IDLE sequence.
- Earliest IDLE re-entry after EMIT: the cycle after both sensors are seen low. Back-to-back coins are then accepted.

## Test plan
- Reset: hold `rst` for 3 cycles with both sensors high. Required: `coin`=00, `reject`=0, `jam`=0, `accepted_cnt`=0 throughout; after release, `reject` pulses once.
- Clean 5-unit coin: `enable`=1, `sense_5` high for 10 cycles from edge 0. Required: `coin`=01 only after edge 6 for one cycle; `accepted_cnt`=1; `reject` stays 0.
- Glitch: `sense_10` high for 4 cycles, then high for 3 cycles after a 2-cycle gap. Required: no `coin`, no `reject`, FSM back in IDLE.
- Ambiguous coin: `sense_5` rises, then `sense_10` rises 2 cycles later while still debouncing. Required: one `reject` pulse, no `coin`. A subsequent clean 10-unit coin yields `coin`=10.
- Disabled plus jam: with `enable`=0, `sense_10` high for 1100 cycles. Required: one `reject` pulse, then `jam`=1 after `JAM_CYCLES`; `jam` clears 3 cycles after the raw sensor drops.
- Saturation: 256 clean 10-unit coins. Required: 256 `coin`=10 pulses; `accepted_cnt` holds at 255 and does not wrap to 0.
